elevator_scan_ctrl: RTL and testbench

Parametrised elevator car controller: the next generation of the fixed four-floor `elevator` core. It serves up to `FLOORS` floors and latches any number of pending calls. It schedules them with SCAN (collective) ordering, keeping the current direction while requests remain ahead. Travel and door times are parametrised in clock cycles. It sits in `elevator_top` behind the debounce/synchroniser stage and drives the HEX/LED display logic.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_cnt.sv | 31 +++
 rtl/elevator_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and constants for the SCAN elevator controller.
//   state_e   : FSM states IDLE / MOVE / DOOR
//   DIR_*     : direction encoding as seen on dir_o
//   max_i     : helper used to size the shared down-counter
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_cnt.sv
// elevator_cnt: loadable down-counter with a terminal flag.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i this cycle (wins over decrement)
//   load_val_i  : value to load; the owner state then lasts load_val_i cycles
//   done_o      : high in the last cycle of a loaded interval (count == 1)
module elevator_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Terminal at 1 rather than 0 so a load of N gives exactly N cycles.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN (collective) elevator car controller.
//   clk, rst     : clock, synchronous active-high reset
//   call_i       : one-cycle call pulses per floor
//   floor_o      : current or last-passed floor
//   dir_o        : 00 idle/door, 01 up, 10 down
//   moving_o     : high while in MOVE
//   door_open_o  : high while in DOOR
//   arrive_o     : one-cycle pulse on each floor change
//   pending_o    : latched call lamps
// All outputs are registered.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 8,
    parameter int TRAVEL_CYC = 50_000_000,
    parameter int DOOR_CYC   = 100_000_000,
    localparam int FLOOR_W   = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  call_i,
    output logic [FLOOR_W-1:0] floor_o,
    output logic [1:0]         dir_o,
    output logic               moving_o,
    output logic               door_open_o,
    output logic               arrive_o,
    output logic [FLOORS-1:0]  pending_o
);

    localparam int CNT_W = $clog2(max_i(TRAVEL_CYC, DOOR_CYC) + 1);

    state_e              state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [1:0]          last_dir_q, last_dir_d;
    logic [FLOORS-1:0]   pending_q, pending_d;
    logic [1:0]          dir_q, dir_d;
    logic                moving_q, moving_d;
    logic                door_q, door_d;
    logic                arrive_q, arrive_d;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_done;

    logic [FLOOR_W-1:0]  nf;        // floor reached at the end of this segment
    logic                above, below;
    logic                ahead;     // requests beyond nf in the travel direction
    logic [FLOORS-1:0]   clr;
    logic [FLOORS-1:0]   set;
    logic                go_up;

    elevator_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    always_comb begin
        nf = (last_dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

        above = 1'b0;
        below = 1'b0;
        ahead = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor_q)) above = above | pending_q[i];
            if (i < int'(floor_q)) below = below | pending_q[i];
            if (last_dir_q == DIR_UP   && i > int'(nf)) ahead = ahead | pending_q[i];
            if (last_dir_q == DIR_DOWN && i < int'(nf)) ahead = ahead | pending_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        last_dir_d = last_dir_q;
        arrive_d   = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        clr        = '0;
        go_up      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d      = DOOR;
                    cnt_load     = 1'b1;
                    cnt_val      = CNT_W'(DOOR_CYC);
                    clr[floor_q] = 1'b1;
                end else if (|pending_q) begin
                    // Keep the previous sweep direction while it still has work.
                    go_up      = (last_dir_q == DIR_UP) ? above : !below;
                    state_d    = MOVE;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(TRAVEL_CYC);
                    last_dir_d = go_up ? DIR_UP : DIR_DOWN;
                end
            end
            MOVE: begin
                if (cnt_done) begin
                    floor_d  = nf;
                    arrive_d = 1'b1;
                    if (pending_q[nf]) begin
                        state_d  = DOOR;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(DOOR_CYC);
                        clr[nf]  = 1'b1;
                    end else if (ahead) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(TRAVEL_CYC);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR: begin
                // A repeat call at this floor holds the door instead of latching.
                if (call_i[floor_q]) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(DOOR_CYC);
                end else if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        set = call_i;
        if (state_q == DOOR) set[floor_q] = 1'b0;
        // Clear wins over a same-cycle set.
        pending_d = (pending_q | set) & ~clr;

        moving_d = (state_d == MOVE);
        door_d   = (state_d == DOOR);
        dir_d    = (state_d == MOVE) ? last_dir_d : DIR_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            floor_q    <= '0;
            last_dir_q <= DIR_UP;
            pending_q  <= '0;
            dir_q      <= DIR_IDLE;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            arrive_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            last_dir_q <= last_dir_d;
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            door_q     <= door_d;
            arrive_q   <= arrive_d;
        end
    end

    assign floor_o     = floor_q;
    assign dir_o       = dir_q;
    assign moving_o    = moving_q;
    assign door_open_o = door_q;
    assign arrive_o    = arrive_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: directed bench for elevator_scan_ctrl with
// FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=3. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too.
module tb_elevator_scan_ctrl;

    localparam int FLOORS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] call_i = '0;
    logic [2:0] floor_o;
    logic [1:0] dir_o;
    logic       moving_o, door_open_o, arrive_o;
    logic [7:0] pending_o;

    int errors = 0;
    int checks = 0;

    elevator_scan_ctrl #(.FLOORS(FLOORS), .TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .call_i      (call_i),
        .floor_o     (floor_o),
        .dir_o       (dir_o),
        .moving_o    (moving_o),
        .door_open_o (door_open_o),
        .arrive_o    (arrive_o),
        .pending_o   (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Assert calls for one cycle; returns in the cycle after the pulse.
    task automatic pulse(input logic [7:0] m);
        call_i = m;
        tick();
        call_i = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((door_open_o || moving_o) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk({tag, "_idle_to"}, 0, 1);
    endtask

    // Wait for the next door opening after a move; check floor, arrival and
    // the direction travelled on the way there. Returns in the first door cycle.
    task automatic wait_stop(input string tag, input logic [2:0] f, input logic [1:0] d);
        int   n = 0;
        logic [1:0] seen = 2'b00;
        while (door_open_o && n < 200) begin
            tick();
            n++;
        end
        while (!door_open_o && n < 200) begin
            tick();
            n++;
            if (moving_o) seen = dir_o;
        end
        if (n >= 200) begin
            chk({tag, "_to"}, 0, 1);
        end else begin
            chk({tag, "_floor"}, 32'(floor_o), 32'(f));
            chk({tag, "_dir"}, 32'(seen), 32'(d));
            chk({tag, "_arrive"}, 32'(arrive_o), 1);
        end
    endtask

    initial begin
        // 1: reset
        tick(2);
        rst = 1'b0;
        tick();
        chk("rst_floor", 32'(floor_o), 0);
        chk("rst_dir", 32'(dir_o), 0);
        chk("rst_pend", 32'(pending_o), 0);
        chk("rst_mov", 32'(moving_o), 0);
        chk("rst_door", 32'(door_open_o), 0);

        // 2: call at current floor
        pulse(8'h01);                                  // t+1
        chk("c0_pend_set", 32'(pending_o), 32'h01);
        chk("c0_door_t1", 32'(door_open_o), 0);
        tick();                                        // t+2
        chk("c0_pend_clr", 32'(pending_o), 0);
        chk("c0_door_t2", 32'(door_open_o), 1);
        chk("c0_dir_t2", 32'(dir_o), 0);
        tick(2);                                       // t+4
        chk("c0_door_t4", 32'(door_open_o), 1);
        tick();                                        // t+5
        chk("c0_door_t5", 32'(door_open_o), 0);
        chk("c0_mov_t5", 32'(moving_o), 0);

        // 3: call to floor 3
        pulse(8'h08);                                  // t+1
        chk("c3_pend", 32'(pending_o), 32'h08);
        chk("c3_mov_t1", 32'(moving_o), 0);
        tick();                                        // t+2
        chk("c3_mov_t2", 32'(moving_o), 1);
        chk("c3_dir_t2", 32'(dir_o), 32'h1);
        tick(3);                                       // t+5
        chk("c3_floor_t5", 32'(floor_o), 0);
        tick();                                        // t+6
        chk("c3_floor_t6", 32'(floor_o), 1);
        chk("c3_arr_t6", 32'(arrive_o), 1);
        chk("c3_mov_t6", 32'(moving_o), 1);
        tick();                                        // t+7
        chk("c3_arr_t7", 32'(arrive_o), 0);
        tick(3);                                       // t+10
        chk("c3_floor_t10", 32'(floor_o), 2);
        chk("c3_arr_t10", 32'(arrive_o), 1);
        tick(4);                                       // t+14
        chk("c3_floor_t14", 32'(floor_o), 3);
        chk("c3_door_t14", 32'(door_open_o), 1);
        chk("c3_mov_t14", 32'(moving_o), 0);
        chk("c3_pend_t14", 32'(pending_o), 0);
        tick(2);                                       // t+16
        chk("c3_door_t16", 32'(door_open_o), 1);
        tick();                                        // t+17
        chk("c3_door_t17", 32'(door_open_o), 0);

        // 4: calls at 1 and 4 while heading from 3 to 6
        pulse(8'h40);
        tick();
        chk("s4_mov", 32'(moving_o), 1);
        pulse(8'h12);
        wait_stop("s4_a", 3'd4, 2'b01);
        chk("s4_pend", 32'(pending_o), 32'h42);
        wait_stop("s4_b", 3'd6, 2'b01);
        wait_stop("s4_c", 3'd1, 2'b10);
        chk("s4_pend_end", 32'(pending_o), 0);

        // 5a: idle at 3 with last direction up, calls 5 and 1 together
        wait_idle("s5_0");
        pulse(8'h08);
        wait_stop("s5_pos", 3'd3, 2'b01);
        wait_idle("s5_1");
        pulse(8'h22);
        wait_stop("s5_a", 3'd5, 2'b01);
        wait_stop("s5_b", 3'd1, 2'b10);

        // 5b: idle at 3 with last direction down, same calls
        wait_idle("s5_2");
        pulse(8'h40);
        wait_stop("s5_up6", 3'd6, 2'b01);
        wait_idle("s5_3");
        pulse(8'h08);
        wait_stop("s5_dn3", 3'd3, 2'b10);
        wait_idle("s5_4");
        pulse(8'h22);
        wait_stop("s5_c", 3'd1, 2'b10);
        wait_stop("s5_d", 3'd5, 2'b01);

        // Door reload: repeat call at 5 while the door is open (d = first door cycle)
        tick();                                        // d+1
        pulse(8'h20);                                  // d+2
        chk("rl_pend", 32'(pending_o), 0);
        chk("rl_door_d2", 32'(door_open_o), 1);
        tick(2);                                       // d+4
        chk("rl_door_d4", 32'(door_open_o), 1);
        tick();                                        // d+5
        chk("rl_door_d5", 32'(door_open_o), 0);

        // 6: reset mid-segment with calls pending
        pulse(8'h44);
        tick(2);
        chk("r6_mov_pre", 32'(moving_o), 1);
        rst = 1'b1;
        tick();
        chk("r6_floor", 32'(floor_o), 0);
        chk("r6_pend", 32'(pending_o), 0);
        chk("r6_mov", 32'(moving_o), 0);
        chk("r6_door", 32'(door_open_o), 0);
        chk("r6_dir", 32'(dir_o), 0);
        rst = 1'b0;
        tick(3);
        chk("r6_mov_post", 32'(moving_o), 0);
        chk("r6_door_post", 32'(door_open_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
